// File: rtl/hazard_unit_pkg.sv
// Shared encodings and widths for the pipeline hazard unit.
package hazard_unit_pkg;
  localparam int REG_W       = 3;
  localparam int STALL_CNT_W = 16;
  localparam int FLUSH_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    LDSTALL = 2'd2,
    HALTED  = 2'd3
  } state_e;
endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline status in, pipeline control out.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [REG_W-1:0]       rs_ID;
  logic [REG_W-1:0]       rt_ID;
  logic                   uses_rs_ID;
  logic                   uses_rt_ID;
  logic                   mem_read_EX;
  logic [REG_W-1:0]       target_WBEX;
  logic                   reg_wrt_EX;
  logic                   redirect_EX;
  logic                   halt_EX;
  logic                   mem_busy;

  logic                   stall_PC;
  logic                   stall_IFID;
  logic                   stall;
  logic                   bubble_IDEX;
  logic                   flush_IFID;
  logic                   freeze;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [1:0]             state;

  modport master (
    output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, mem_read_EX, target_WBEX,
           reg_wrt_EX, redirect_EX, halt_EX, mem_busy,
    input  stall_PC, stall_IFID, stall, bubble_IDEX, flush_IFID, freeze,
           stall_cnt, flush_cnt, state
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, mem_read_EX, target_WBEX,
           reg_wrt_EX, redirect_EX, halt_EX, mem_busy,
    output stall_PC, stall_IFID, stall, bubble_IDEX, flush_IFID, freeze,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // count up on i_inc, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}})) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: Mealy FSM resolving halt, memory wait, redirect
// and load-use hazards, plus saturating stall/flush event counters.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hif
);
  state_e r_state, w_next;
  logic   r_lu_sup, w_lu_sup_nxt;
  logic   w_load_use, w_lu_live;
  logic   w_stall_pc, w_stall_ifid, w_stall_raw, w_bubble, w_flush, w_freeze;

  assign w_load_use = hif.mem_read_EX & hif.reg_wrt_EX &
                      ((hif.uses_rs_ID & (hif.rs_ID == hif.target_WBEX)) |
                       (hif.uses_rt_ID & (hif.rt_ID == hif.target_WBEX)));

  // A load-use already paid for by LDSTALL stays suppressed, even if a
  // memory wait intervenes between LDSTALL and the return to RUN.
  assign w_lu_live = w_load_use & (r_state != LDSTALL) &
                     ~((r_state == MEMWAIT) & r_lu_sup);

  // state register plus the MEMWAIT load-use suppression flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_lu_sup <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_lu_sup <= w_lu_sup_nxt;
    end
  end

  // next state and control outputs; RUN/LDSTALL/MEMWAIT share one priority chain
  always_comb begin
    w_next       = r_state;
    w_lu_sup_nxt = 1'b0;
    w_stall_pc   = 1'b0;
    w_stall_ifid = 1'b0;
    w_stall_raw  = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_freeze     = 1'b0;
    if (r_state == HALTED || hif.halt_EX) begin
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
      w_bubble     = 1'b1;
      w_next       = HALTED;
    end else if (hif.mem_busy) begin
      w_freeze     = 1'b1;
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
      w_stall_raw  = 1'b1;
      w_next       = MEMWAIT;
      w_lu_sup_nxt = (r_state == LDSTALL) | ((r_state == MEMWAIT) & r_lu_sup);
    end else if (hif.redirect_EX) begin
      w_flush      = 1'b1;
      w_bubble     = 1'b1;
      w_next       = RUN;
    end else if (w_lu_live) begin
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
      w_bubble     = 1'b1;
      w_next       = LDSTALL;
    end else begin
      w_next       = RUN;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_stall_pc), .o_cnt(hif.stall_cnt)
  );

  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_flush), .o_cnt(hif.flush_cnt)
  );

  assign hif.stall_PC    = w_stall_pc;
  assign hif.stall_IFID  = w_stall_ifid;
  assign hif.stall       = w_stall_raw & ~w_bubble;  // a bubble must be written
  assign hif.bubble_IDEX = w_bubble;
  assign hif.flush_IFID  = w_flush;
  assign hif.freeze      = w_freeze;
  assign hif.state       = r_state;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a rule-level reference model.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if hif ();
  hazard_unit dut (.clk(clk), .rst(rst), .hif(hif));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit spc, sifid, stl, bub, fl, frz, sup;
    logic [1:0] nxt;
  } exp_t;

  logic [1:0] m_state = 2'd0;   // 0 run, 1 memwait, 2 ldstall, 3 halted
  bit         m_sup   = 1'b0;   // memwait that was entered from ldstall
  int         m_scnt  = 0;
  int         m_fcnt  = 0;
  exp_t       e_now;

  function automatic exp_t expect_now();
    exp_t e;
    bit   lu;
    e  = '0;
    lu = hif.mem_read_EX && hif.reg_wrt_EX &&
         ((hif.uses_rs_ID && hif.rs_ID == hif.target_WBEX) ||
          (hif.uses_rt_ID && hif.rt_ID == hif.target_WBEX));
    if (m_state == 2) lu = 0;
    if (m_state == 1 && m_sup) lu = 0;
    if (m_state == 3 || hif.halt_EX) begin
      e.spc = 1; e.sifid = 1; e.bub = 1; e.nxt = 3;
    end else if (hif.mem_busy) begin
      e.frz = 1; e.spc = 1; e.sifid = 1; e.stl = 1; e.nxt = 1;
      e.sup = (m_state == 2) || (m_state == 1 && m_sup);
    end else if (hif.redirect_EX) begin
      e.fl = 1; e.bub = 1; e.nxt = 0;
    end else if (lu) begin
      e.spc = 1; e.sifid = 1; e.bub = 1; e.nxt = 2;
    end else begin
      e.nxt = 0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 2'd0; m_sup <= 1'b0; m_scnt <= 0; m_fcnt <= 0;
    end else begin
      exp_t e;
      e = expect_now();
      if (e.spc && m_scnt < 65535) m_scnt <= m_scnt + 1;
      if (e.fl  && m_fcnt < 255)   m_fcnt <= m_fcnt + 1;
      m_state <= e.nxt;
      m_sup   <= e.sup;
    end
  end

  // every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    e_now = expect_now();
    chk("cmp_state",  hif.state,       m_state);
    chk("cmp_spc",    hif.stall_PC,    e_now.spc);
    chk("cmp_sifid",  hif.stall_IFID,  e_now.sifid);
    chk("cmp_stall",  hif.stall,       e_now.stl && !e_now.bub);
    chk("cmp_bubble", hif.bubble_IDEX, e_now.bub);
    chk("cmp_flush",  hif.flush_IFID,  e_now.fl);
    chk("cmp_freeze", hif.freeze,      e_now.frz);
    chk("cmp_scnt",   hif.stall_cnt,   m_scnt);
    chk("cmp_fcnt",   hif.flush_cnt,   m_fcnt);
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    hif.rs_ID = 0; hif.rt_ID = 0; hif.uses_rs_ID = 0; hif.uses_rt_ID = 0;
    hif.mem_read_EX = 0; hif.target_WBEX = 0; hif.reg_wrt_EX = 0;
    hif.redirect_EX = 0; hif.halt_EX = 0; hif.mem_busy = 0;
  endtask
  task automatic lw_use(input logic [2:0] r);
    hif.mem_read_EX = 1; hif.reg_wrt_EX = 1; hif.target_WBEX = r;
    hif.rs_ID = r; hif.uses_rs_ID = 1;
  endtask
  task automatic mid(); @(negedge clk); #1; endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  int frz_n;

  initial begin
    clr(); rst = 0;
    nxt(); nxt();
    mid();
    chk("rst_state", hif.state, 0);
    chk("rst_scnt",  hif.stall_cnt, 0);
    chk("rst_fcnt",  hif.flush_cnt, 0);
    rst = 1;
    nxt();

    // load-use through rs: one stall cycle, then LDSTALL with hazard suppressed
    lw_use(3);
    mid();
    chk("lu_spc", hif.stall_PC, 1); chk("lu_ifid", hif.stall_IFID, 1);
    chk("lu_bub", hif.bubble_IDEX, 1); chk("lu_stall", hif.stall, 0);
    nxt(); mid();
    chk("ld_state", hif.state, 2); chk("ld_spc", hif.stall_PC, 0);
    chk("ld_bub", hif.bubble_IDEX, 0); chk("ld_scnt", hif.stall_cnt, 1);
    nxt(); clr();
    // load-use through rt
    hif.mem_read_EX = 1; hif.reg_wrt_EX = 1; hif.target_WBEX = 5;
    hif.rt_ID = 5; hif.uses_rt_ID = 1; hif.rs_ID = 5;
    mid(); chk("lurt_spc", hif.stall_PC, 1);
    nxt(); clr(); nxt();
    // non-hazards: index match but not used, and no register write
    hif.mem_read_EX = 1; hif.reg_wrt_EX = 1; hif.target_WBEX = 3;
    hif.rs_ID = 3; hif.rt_ID = 4; hif.uses_rt_ID = 1;
    mid(); chk("nouse_spc", hif.stall_PC, 0);
    nxt(); lw_use(3); hif.reg_wrt_EX = 0;
    mid(); chk("nowr_spc", hif.stall_PC, 0);
    nxt(); clr();

    // redirect beats load-use in the same cycle
    lw_use(2); hif.redirect_EX = 1;
    mid();
    chk("rd_flush", hif.flush_IFID, 1); chk("rd_bub", hif.bubble_IDEX, 1);
    chk("rd_spc", hif.stall_PC, 0);
    nxt(); clr(); mid();
    chk("rd_fcnt", hif.flush_cnt, 1); chk("rd_state", hif.state, 0);
    nxt();

    // memory busy for four cycles (stall_cnt 2 -> 6)
    frz_n = 0;
    hif.mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      mid(); if (hif.freeze) frz_n++;
      nxt();
    end
    hif.mem_busy = 0;
    mid(); chk("mw_state", hif.state, 1); if (hif.freeze) frz_n++;
    nxt(); mid();
    chk("mw_frz_n", frz_n, 4); chk("mw_scnt", hif.stall_cnt, 6);
    chk("mw_run", hif.state, 0);
    nxt();

    // load-use deferred behind memory wait is acted on at exit (6 -> 9)
    lw_use(1); hif.mem_busy = 1;
    nxt(); nxt(); hif.mem_busy = 0;
    mid(); chk("dlu_spc", hif.stall_PC, 1); chk("dlu_bub", hif.bubble_IDEX, 1);
    nxt(); mid(); chk("dlu_state", hif.state, 2);
    nxt(); clr(); nxt();

    // memory wait during LDSTALL: load-use not re-raised on exit (9 -> 12)
    lw_use(4);
    nxt(); hif.mem_busy = 1;
    mid(); chk("lsm_frz", hif.freeze, 1);
    nxt(); nxt(); hif.mem_busy = 0;
    mid(); chk("lsm_spc", hif.stall_PC, 0); chk("lsm_scnt", hif.stall_cnt, 12);
    nxt(); clr(); mid(); chk("lsm_state", hif.state, 0);
    nxt();

    // redirect deferred behind memory wait (12 -> 13, flush 1 -> 2)
    hif.redirect_EX = 1; hif.mem_busy = 1;
    nxt(); hif.mem_busy = 0;
    mid(); chk("drd_flush", hif.flush_IFID, 1);
    nxt(); clr(); mid(); chk("drd_fcnt", hif.flush_cnt, 2);
    nxt();

    // halt: 100 stall cycles total, other inputs ignored (13 -> 113)
    hif.halt_EX = 1;
    mid(); chk("h_spc", hif.stall_PC, 1); chk("h_stall", hif.stall, 0);
    nxt(); clr(); hif.mem_busy = 1; hif.redirect_EX = 1; lw_use(6);
    repeat (99) nxt();
    mid();
    chk("h_state", hif.state, 3); chk("h_scnt", hif.stall_cnt, 113);
    chk("h_frz", hif.freeze, 0); chk("h_flush", hif.flush_IFID, 0);
    #1 rst = 0;
    #1;
    chk("hr_state", hif.state, 0); chk("hr_scnt", hif.stall_cnt, 0);
    chk("hr_fcnt", hif.flush_cnt, 0); chk("hr_frz", hif.freeze, 1);
    clr();
    nxt(); rst = 1; nxt();

    // saturation of both counters
    hif.mem_busy = 1;
    repeat (70000) nxt();
    mid(); chk("sat_scnt", hif.stall_cnt, 16'hFFFF);
    nxt(); hif.mem_busy = 0; nxt();
    hif.redirect_EX = 1;
    repeat (300) nxt();
    mid(); chk("sat_fcnt", hif.flush_cnt, 8'hFF);
    nxt(); clr(); mid();
    chk("sat_state", hif.state, 0); chk("sat_scnt2", hif.stall_cnt, 16'hFFFF);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
